// File: rtl/assoc_wb_cache.sv
// rtl/assoc_wb_cache.sv - N-way set-associative write-back, write-allocate blocking data cache
// Beat-based line fill / dirty write-back, per-set round-robin replacement, hit/miss counters.
module assoc_wb_cache #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int WAYS       = 2,
  parameter int SETS_LOG2  = 4,
  parameter int WORDS_LOG2 = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_write,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int OFF_W  = BYTE_W + WORDS_LOG2;
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - SETS_LOG2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETS   = 1 << SETS_LOG2;
  localparam int WORDS  = 1 << WORDS_LOG2;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, RESPOND} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  victim_fresh_q;
  logic [WORDS_LOG2-1:0] beat_q;

  logic                  valid_mem [WAYS][SETS];
  logic                  dirty_mem [WAYS][SETS];
  logic [TAG_W-1:0]      tag_mem   [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_mem  [WAYS][SETS][WORDS];
  logic [WAY_W-1:0]      rr_mem    [SETS];

  logic [WORDS_LOG2-1:0] req_word;
  logic [SETS_LOG2-1:0]  req_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  unused_bits;
  assign req_word    = addr_q[BYTE_W +: WORDS_LOG2];
  assign req_index   = addr_q[OFF_W +: SETS_LOG2];
  assign req_tag     = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign unused_bits = ^(addr_q & ADDR_WIDTH'((1 << BYTE_W) - 1));

  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, victim;
  logic             victim_dirty;

  // Scan downwards so the lowest-numbered invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[w][req_index] && tag_mem[w][req_index] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_mem[w][req_index]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim       = inv_found ? inv_way : rr_mem[req_index];
    victim_dirty = valid_mem[victim][req_index] && dirty_mem[victim][req_index];
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    case (state)
      IDLE: begin
        req_ready = reset;
        if (req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit)               state_next = RESPOND;
        else if (victim_dirty) state_next = WB_REQ;
        else                   state_next = FILL_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_mem[victim_q][req_index], req_index, {OFF_W{1'b0}}};
        if (mem_req_ready) state_next = WB_DATA;
      end
      WB_DATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = data_mem[victim_q][req_index][beat_q];
        if (mem_wready && beat_q == WORDS_LOG2'(WORDS - 1)) state_next = FILL_REQ;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index, {OFF_W{1'b0}}};
        if (mem_req_ready) state_next = FILL_DATA;
      end
      FILL_DATA: begin
        if (mem_rvalid && beat_q == WORDS_LOG2'(WORDS - 1)) state_next = RESPOND;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_mem[w][s] <= 1'b0;
          dirty_mem[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < SETS; s++) rr_mem[s] <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      resp_data  <= '0;
      beat_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          write_q <= req_write;
          wdata_q <= req_wdata;
        end
        LOOKUP: if (hit) begin
          hit_count <= hit_count + CNT_WIDTH'(1);
          if (write_q) begin
            data_mem[hit_way][req_index][req_word] <= wdata_q;
            dirty_mem[hit_way][req_index]          <= 1'b1;
            resp_data                              <= '0;
          end else begin
            resp_data <= data_mem[hit_way][req_index][req_word];
          end
        end else begin
          miss_count     <= miss_count + CNT_WIDTH'(1);
          victim_q       <= victim;
          victim_fresh_q <= inv_found;
          beat_q         <= '0;
        end
        WB_DATA: if (mem_wready) beat_q <= beat_q + WORDS_LOG2'(1);
        FILL_DATA: if (mem_rvalid) begin
          data_mem[victim_q][req_index][beat_q] <= mem_rdata;
          beat_q <= beat_q + WORDS_LOG2'(1);
          if (beat_q == WORDS_LOG2'(WORDS - 1)) begin
            valid_mem[victim_q][req_index] <= 1'b1;
            tag_mem[victim_q][req_index]   <= req_tag;
            dirty_mem[victim_q][req_index] <= write_q;
            if (WAYS > 1 && !victim_fresh_q)
              rr_mem[req_index] <= rr_mem[req_index] + WAY_W'(1);
            // Replay as a hit: the later store write overrides the fill beat on the same word.
            if (write_q) begin
              data_mem[victim_q][req_index][req_word] <= wdata_q;
              resp_data <= '0;
            end else begin
              resp_data <= (req_word == beat_q) ? mem_rdata : data_mem[victim_q][req_index][req_word];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_assoc_wb_cache.sv
// tb/tb_assoc_wb_cache.sv - scoreboard bench for assoc_wb_cache with a beat-level memory responder
module tb_assoc_wb_cache;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [63:0] resp_data;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
  logic [63:0] mem_req_addr;
  logic        mem_wvalid, mem_wready = 1'b0;
  logic [63:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic [31:0] hit_count, miss_count;

  assoc_wb_cache dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;
  int accept_cyc = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mreq_addr_q[$];
  logic        mreq_write_q[$];
  logic [63:0] wb_q[$];
  logic [63:0] model [logic [63:0]];

  logic        wr_toggle = 1'b0;
  int          cur_beat = -1;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (model.exists(a)) return model[a];
    return 64'h0;
  endfunction

  // Memory responder: always ready for requests, fill beats on consecutive cycles.
  initial begin
    logic        rd_active = 1'b0;
    int          rd_idx = 0;
    logic [63:0] rd_base = '0, wb_base = '0, stall_data = '0;
    int          wb_idx = 0, wcnt = 0;
    logic        stalled = 1'b0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (!reset) begin
        rd_active = 1'b0; mem_wready = 1'b0; mem_req_ready = 1'b0; stalled = 1'b0; cur_beat = -1;
        continue;
      end
      mem_req_ready = 1'b1;
      if (rd_active) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_rd(rd_base + 64'(8 * rd_idx));
        cur_beat   = rd_idx;
        rd_idx++;
        if (rd_idx == 4) rd_active = 1'b0;
      end
      if (mem_req_valid) begin
        mreq_addr_q.push_back(mem_req_addr);
        mreq_write_q.push_back(mem_req_write);
        if (mem_req_write) begin
          wb_base = mem_req_addr; wb_idx = 0; wcnt = 0;
        end else begin
          rd_active = 1'b1; rd_idx = 0; rd_base = mem_req_addr;
        end
      end
      if (mem_wvalid) begin
        if (stalled) begin
          checks++;
          if (mem_wdata !== stall_data) begin
            errors++;
            $display("FAIL wdata_stable got %h exp %h", mem_wdata, stall_data);
          end
        end
        mem_wready = wr_toggle ? (wcnt % 3 == 0) : 1'b1;
        wcnt++;
        if (mem_wready) begin
          wb_q.push_back(mem_wdata);
          model[wb_base + 64'(8 * wb_idx)] = mem_wdata;
          wb_idx++;
        end
        stalled    = !mem_wready;
        stall_data = mem_wdata;
      end else begin
        mem_wready = 1'b0;
        stalled    = 1'b0;
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [63:0] e);
    int n = 0;
    @(negedge clk);
    req_addr = a; req_write = w; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout got req_ready=%b exp 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    accept_cyc = cycle;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    int n = 0;
    logic [63:0] e;
    lat = -1;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 300);
    checks++;
    if (!resp_valid) begin
      errors++;
      $display("FAIL resp_timeout got resp_valid=0 exp 1");
      return;
    end
    lat = cycle - accept_cyc;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %h exp none", resp_data);
    end else begin
      e = exp_q.pop_front();
      if (resp_data !== e) begin
        errors++;
        $display("FAIL resp_data got %h exp %h", resp_data, e);
      end
    end
    if (resp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic check_mreq(input string nm, input logic [63:0] a, input logic w);
    checks++;
    if (mreq_addr_q.size() == 0) begin
      errors++;
      $display("FAIL %s got no mem request exp addr %h", nm, a);
      return;
    end
    begin
      logic [63:0] ga;
      logic        gw;
      ga = mreq_addr_q.pop_front();
      gw = mreq_write_q.pop_front();
      if (ga !== a || gw !== w) begin
        errors++;
        $display("FAIL %s got addr %h write %b exp addr %h write %b", nm, ga, gw, a, w);
      end
    end
  endtask

  task automatic check_counts(input string nm, input int h, input int m);
    checks++;
    if (hit_count !== 32'(h) || miss_count !== 32'(m)) begin
      errors++;
      $display("FAIL %s got hit %0d miss %0d exp hit %0d miss %0d", nm, hit_count, miss_count, h, m);
    end
  endtask

  task automatic check_wb(input string nm, input logic [63:0] b0, b1, b2, b3);
    logic [63:0] exp_b [4];
    exp_b = '{b0, b1, b2, b3};
    checks++;
    if (wb_q.size() != 4) begin
      errors++;
      $display("FAIL %s_count got %0d exp 4", nm, wb_q.size());
    end
    for (int i = 0; i < 4 && i < wb_q.size(); i++) begin
      checks++;
      if (wb_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL %s_beat%0d got %h exp %h", nm, i, wb_q[i], exp_b[i]);
      end
    end
    wb_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_wvalid !== 1'b0 ||
        mem_req_write !== 1'b0 || resp_data !== 64'h0 || mem_req_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs got rr=%b rv=%b mv=%b wv=%b rd=%h exp all 0",
               req_ready, resp_valid, mem_req_valid, mem_wvalid, resp_data);
    end
    check_counts("reset_counters", 0, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_load_miss();
    int lat;
    issue(64'h1008, 1'b0, 64'h0, 64'h22);
    wait_resp(lat);
    check_mreq("miss_fill_req", 64'h1000, 1'b0);
    check_counts("miss_counts", 0, 1);
  endtask

  task automatic test_hit_latency();
    int lat;
    issue(64'h1018, 1'b0, 64'h0, 64'h44);
    wait_resp(lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL hit_latency got %0d exp 2", lat);
    end
    checks++;
    if (mreq_addr_q.size() != 0) begin
      errors++;
      $display("FAIL hit_no_mem_req got %0d requests exp 0", mreq_addr_q.size());
    end
    check_counts("hit_counts", 1, 1);
  endtask

  task automatic test_evict();
    int lat;
    issue(64'h1000, 1'b1, 64'hAA, 64'h0);
    wait_resp(lat);
    issue(64'h3000, 1'b0, 64'h0, 64'h31);
    wait_resp(lat);
    check_mreq("fill_way1", 64'h3000, 1'b0);
    issue(64'h5000, 1'b0, 64'h0, 64'h51);
    wait_resp(lat);
    check_mreq("wb_req", 64'h1000, 1'b1);
    check_mreq("fill_after_wb", 64'h5000, 1'b0);
    check_wb("wb", 64'hAA, 64'h22, 64'h33, 64'h44);
    check_counts("evict_counts", 2, 3);
  endtask

  task automatic test_store_miss();
    int lat;
    issue(64'h7008, 1'b1, 64'h55, 64'h0);
    wait_resp(lat);
    check_mreq("store_miss_fill", 64'h7000, 1'b0);
    issue(64'h7008, 1'b0, 64'h0, 64'h55);
    wait_resp(lat);
    checks++;
    if (mreq_addr_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL store_merge_hit got %0d mem requests exp 0", mreq_addr_q.size());
    end
    check_counts("store_miss_counts", 3, 4);
  endtask

  task automatic test_backpressure();
    int lat;
    resp_ready = 1'b0;
    issue(64'h7000, 1'b0, 64'h0, 64'h71);
    wait_resp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 64'h71 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold%0d got rv=%b rd=%h rr=%b exp rv=1 rd=71 rr=0",
                 i, resp_valid, resp_data, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got rr=%b rv=%b exp rr=1 rv=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_wready_toggle();
    int lat;
    issue(64'h1000, 1'b0, 64'h0, 64'hAA);
    wait_resp(lat);
    check_mreq("refill_written_back", 64'h1000, 1'b0);
    wr_toggle = 1'b1;
    issue(64'h3000, 1'b0, 64'h0, 64'h31);
    wait_resp(lat);
    wr_toggle = 1'b0;
    check_mreq("toggle_wb_req", 64'h7000, 1'b1);
    check_mreq("toggle_fill", 64'h3000, 1'b0);
    check_wb("toggle_wb", 64'h71, 64'h55, 64'h73, 64'h74);
    check_counts("toggle_counts", 4, 6);
  endtask

  task automatic test_reset_mid_fill();
    int lat;
    int n = 0;
    logic found = 1'b0;
    issue(64'h5008, 1'b0, 64'h0, 64'h52);
    while (n < 200 && !found) begin
      @(negedge clk); #2;
      if (mem_rvalid && cur_beat == 2) found = 1'b1;
      else n++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL third_beat_timeout got none exp beat 2");
    end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_wvalid !== 1'b0 ||
        mem_req_write !== 1'b0 || resp_data !== 64'h0 || mem_req_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL midfill_reset_outputs got rr=%b rv=%b mv=%b rd=%h ma=%h exp all 0",
               req_ready, resp_valid, mem_req_valid, resp_data, mem_req_addr);
    end
    check_counts("midfill_reset_counters", 0, 0);
    exp_q.delete();
    mreq_addr_q.delete();
    mreq_write_q.delete();
    @(negedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL abandoned_no_resp got %b exp 0", resp_valid);
      end
    end
    issue(64'h5008, 1'b0, 64'h0, 64'h52);
    wait_resp(lat);
    check_mreq("refill_after_reset", 64'h5000, 1'b0);
    check_counts("refill_counts", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      model[64'h1000 + 64'(8 * i)] = 64'h11 * 64'(i + 1);
      model[64'h3000 + 64'(8 * i)] = 64'h31 + 64'(i);
      model[64'h5000 + 64'(8 * i)] = 64'h51 + 64'(i);
      model[64'h7000 + 64'(8 * i)] = 64'h71 + 64'(i);
    end
    test_reset();
    test_load_miss();
    test_hit_latency();
    test_evict();
    test_store_miss();
    test_backpressure();
    test_wready_toggle();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
